// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one integer ALU between the EX-stage op
// (requester 0) and the branch/address helper (requester 1). The ALU result
// is captured into a one-entry response slot tagged with the requester id.
module alu_share_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  // requester 0: EX-stage integer op
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  // requester 1: branch/address helper
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  // ALU instance
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [XLEN-1:0]   alu_result,
  // responses
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              busy
);

  typedef enum logic [0:0] {StEmpty, StFull} slot_state_e;

  slot_state_e     state_q, state_d;
  logic            slot_id_q;
  logic [XLEN-1:0] rsp_data_q;
  logic            last_grant_q;

  logic winner;
  logic drain;
  logic issue_ok;
  logic issue;

  // Pick the winner: a lone requester wins; under contention the one not
  // granted last time wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_q;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign rsp0_valid = (state_q == StFull) && !slot_id_q;
  assign rsp1_valid = (state_q == StFull) &&  slot_id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q == StFull);

  assign drain = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // rst_n gates the accept so nothing handshakes while reset is held.
  assign issue_ok   = rst_n && !flush && ((state_q == StEmpty) || drain);
  assign req0_ready = issue_ok && !winner && req0_valid;
  assign req1_ready = issue_ok &&  winner && req1_valid;
  assign issue      = req0_ready || req1_ready;

  // Drive the ALU from the winner whenever anyone is valid, even when the
  // slot cannot accept; otherwise park the ALU inputs at zero.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_func = '0;
    if (req0_valid || req1_valid) begin
      if (winner) begin
        alu_a    = req1_a;
        alu_b    = req1_b;
        alu_func = req1_func;
      end else begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_func = req0_func;
      end
    end
  end

  // Slot next state: flush dominates, then issue refills, then drain empties.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (issue) begin
      state_d = StFull;
    end else if (drain) begin
      state_d = StEmpty;
    end
  end

  // Slot state, captured result, owner id and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      slot_id_q    <= 1'b0;
      rsp_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (issue) begin
        slot_id_q    <= winner;
        rsp_data_q   <= alu_result;
        last_grant_q <= winner;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_func;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_func;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_func;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          m_full;
  int          m_id;
  int          m_last;
  logic [31:0] m_data;

  logic [3:0] codes [11] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7, 4'hE};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  func;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] f);
    case (f)
      4'h0:    return a + b;
      4'h8:    return a - b;
      4'h1:    return a << b[4:0];
      4'h2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3:    return (a < b) ? 32'd1 : 32'd0;
      4'h4:    return a ^ b;
      4'h5:    return a >> b[4:0];
      4'hD:    return 32'($signed(a) >>> b[4:0]);
      4'h6:    return a | b;
      4'h7:    return a & b;
      4'hE:    return b;
      default: return 32'd0;
    endcase
  endfunction

  // stand-in for the ALU instance
  assign alu_result = alu_fn(alu_a, alu_b, alu_func);

  alu_share_arbiter #(.XLEN(32), .FUNC_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_func  (req0_func),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_func  (req1_func),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_result (alu_result),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_func = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_func = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  // leaves time at posedge+1 with reset released
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_full = 0; m_id = 0; m_last = 1; m_data = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      int who;
      bit any, drained, can_take, acc0, acc1;
      logic [31:0] ea, eb;
      logic [3:0]  ef;
      flush      = ($urandom_range(0, 15) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = $urandom; req0_b = $urandom; req0_func = codes[$urandom_range(0, 10)];
      req1_a = $urandom; req1_b = $urandom; req1_func = codes[$urandom_range(0, 10)];
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      // who gets the ALU: lone valid wins, contention favours the other side
      any = req0_valid || req1_valid;
      if (req0_valid && req1_valid) who = 1 - m_last;
      else                          who = req1_valid ? 1 : 0;
      drained  = m_full && ((m_id == 0) ? rsp0_ready : rsp1_ready);
      can_take = !flush && (!m_full || drained);
      acc0 = can_take && req0_valid && (who == 0);
      acc1 = can_take && req1_valid && (who == 1);
      ea = !any ? 32'd0 : (who == 0 ? req0_a : req1_a);
      eb = !any ? 32'd0 : (who == 0 ? req0_b : req1_b);
      ef = !any ? 4'd0  : (who == 0 ? req0_func : req1_func);
      check("rnd_req0_ready", 32'(req0_ready), 32'(acc0));
      check("rnd_req1_ready", 32'(req1_ready), 32'(acc1));
      check("rnd_alu_a", alu_a, ea);
      check("rnd_alu_b", alu_b, eb);
      check("rnd_alu_func", 32'(alu_func), 32'(ef));
      check("rnd_rsp0_valid", 32'(rsp0_valid), 32'(m_full && m_id == 0));
      check("rnd_rsp1_valid", 32'(rsp1_valid), 32'(m_full && m_id == 1));
      check("rnd_busy", 32'(busy), 32'(m_full));
      check("rnd_rsp_data", rsp_data, m_data);
      if (flush) begin
        m_full = 0;
      end else if (acc0 || acc1) begin
        m_full = 1;
        m_id   = who;
        m_last = who;
        m_data = alu_fn(ea, eb, ef);
      end else if (drained) begin
        m_full = 0;
      end
      tick();
    end
  endtask

  initial begin
    vecs[0]  = '{32'd5,        32'd7,    4'h0, 32'd12};
    vecs[1]  = '{32'd10,       32'd3,    4'h8, 32'd7};
    vecs[2]  = '{32'd1,        32'h24,   4'h1, 32'd16};
    vecs[3]  = '{32'hFFFFFFFF, 32'd1,    4'h2, 32'd1};
    vecs[4]  = '{32'hFFFFFFFF, 32'd1,    4'h3, 32'd0};
    vecs[5]  = '{32'hF0F0,     32'hFF00, 4'h4, 32'h0FF0};
    vecs[6]  = '{32'h80000000, 32'd4,    4'h5, 32'h08000000};
    vecs[7]  = '{32'h80000000, 32'd4,    4'hD, 32'hF8000000};
    vecs[8]  = '{32'hF0,       32'h0F,   4'h6, 32'hFF};
    vecs[9]  = '{32'hF0,       32'h3C,   4'h7, 32'h30};
    vecs[10] = '{32'hDEAD,     32'h1234, 4'hE, 32'h1234};

    // reset held with a pending request: nothing may be accepted
    clear_inputs();
    rst_n = 0;
    req0_valid = 1; req0_a = 5; req0_b = 7;
    #12;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    do_reset();

    // vector table, alternating requesters
    for (int i = 0; i < 11; i++) begin
      if (i % 2 == 0) begin
        req0_valid = 1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_func = vecs[i].func;
      end else begin
        req1_valid = 1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_func = vecs[i].func;
      end
      @(negedge clk);
      check("vec_ready", 32'((i % 2 == 0) ? req0_ready : req1_ready), 32'd1);
      check("vec_alu_a", alu_a, vecs[i].a);
      check("vec_alu_b", alu_b, vecs[i].b);
      check("vec_alu_func", 32'(alu_func), 32'(vecs[i].func));
      tick();
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      check("vec_rsp_own", 32'((i % 2 == 0) ? rsp0_valid : rsp1_valid), 32'd1);
      check("vec_rsp_other", 32'((i % 2 == 0) ? rsp1_valid : rsp0_valid), 32'd0);
      check("vec_rsp_data", rsp_data, vecs[i].exp);
      tick();
    end

    // contention: grants alternate 0,1,0,1 starting with requester 0
    do_reset();
    req0_valid = 1; req0_a = 10; req0_b = 3; req0_func = 4'h8;
    req1_valid = 1; req1_a = 32'h80000000; req1_b = 4; req1_func = 4'hD;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("cont_req0_ready", 32'(req0_ready), 32'(c % 2 == 0));
      check("cont_req1_ready", 32'(req1_ready), 32'(c % 2 == 1));
      if (c > 0) begin
        check("cont_rsp0_valid", 32'(rsp0_valid), 32'(c % 2 == 1));
        check("cont_rsp1_valid", 32'(rsp1_valid), 32'(c % 2 == 0));
        check("cont_rsp_data", rsp_data, (c % 2 == 1) ? 32'd7 : 32'hF8000000);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // backpressure: req1 result held, req0 blocked until it drains
    rsp1_ready = 0;
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_func = 4'h0;
    @(negedge clk);
    check("bp_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_a = 4; req0_b = 4; req0_func = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_req0_blocked", 32'(req0_ready), 32'd0);
      check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("bp_rsp_data", rsp_data, 32'd3);
      tick();
    end
    rsp1_ready = 1;
    @(negedge clk);
    check("bp_req0_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("bp_rsp1_after", 32'(rsp1_valid), 32'd0);
    check("bp_rsp0_data", rsp_data, 32'd8);
    tick();

    // flush drops a full slot and blocks the issue in the same cycle
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 32'hAA; req0_b = 32'h55; req0_func = 4'h4;
    @(negedge clk);
    check("fl_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    flush = 1;
    req1_valid = 1; req1_a = 2; req1_b = 3; req1_func = 4'h6;
    @(negedge clk);
    check("fl_rsp0_before", 32'(rsp0_valid), 32'd1);
    check("fl_req1_blocked", 32'(req1_ready), 32'd0);
    tick();
    flush = 0;
    @(negedge clk);
    check("fl_rsp0_after", 32'(rsp0_valid), 32'd0);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_data_held", rsp_data, 32'hFF);
    check("fl_req1_accept", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 0;
    @(negedge clk);
    check("fl_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("fl_rsp1_data", rsp_data, 32'd3);
    tick();

    // async reset with the slot full for req0 (last grant = 0 before reset)
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_func = 4'h0;
    @(negedge clk);
    check("ar_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    check("ar_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 0;
    #1;
    check("ar_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_rsp_data", rsp_data, 32'd0);
    #2 rst_n = 1;
    rsp0_ready = 1;
    tick();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check("ar_req0_wins", 32'(req0_ready), 32'd1);
    check("ar_req1_waits", 32'(req1_ready), 32'd0);
    tick();

    // randomized run against the model
    do_reset();
    run_random(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
